// File: rtl/seq_left_shifter_pkg.sv
// Shared definitions for the iterative left shifter: word and shift-amount
// widths plus the controller state encoding.
package seq_left_shifter_pkg;

    localparam int WORD_W  = 32;
    localparam int SHAMT_W = 5;

    // Controller states: waiting, shifting one bit per clock, completion pulse.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // True when the requested amount cannot fit in the counter, meaning every
    // bit of the operand would be shifted out.
    function automatic logic shamt_overflow(input logic [WORD_W-1:0] amount);
        return |amount[WORD_W-1:SHAMT_W];
    endfunction

endpackage

// File: rtl/seq_left_shifter.sv
// Iterative logical left shifter. One bit per clock, zero fill from bit 0.
// The working register doubles as the result output so the final value is
// held in IDLE until the next accepted start.
module seq_left_shifter
    import seq_left_shifter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] result,
    output logic              carry_out
);

    state_t               state;
    logic [WORD_W-1:0]    work;
    logic [SHAMT_W-1:0]   count;

    assign result = work;

    // Controller, datapath and registered status flags in one process so the
    // busy/done flags always change on the same edge as the state they mirror.
    // A start is honoured in IDLE and DONE; in SHIFT it is simply not looked at.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            work      <= '0;
            count     <= '0;
            carry_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        count     <= b[SHAMT_W-1:0];
                        carry_out <= 1'b0;
                        if (shamt_overflow(b)) begin
                            work  <= '0;
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else if (b[SHAMT_W-1:0] == '0) begin
                            work  <= a;
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            work  <= a;
                            state <= SHIFT;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                end

                SHIFT: begin
                    work      <= {work[WORD_W-2:0], 1'b0};
                    carry_out <= work[WORD_W-1];
                    count     <= count - 1'b1;
                    if (count == SHAMT_W'(1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_left_shifter.sv
// Directed bench for seq_left_shifter: a table of single operations plus
// hand-written sequences for ignored start, back-to-back start and reset.
module tb_seq_left_shifter;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        carry_out;

    int compared;
    int mismatched;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_result;
        logic        exp_carry;
        int          exp_busy;
    } vec_t;

    vec_t vecs[9];

    seq_left_shifter dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its expectation and tally it.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Present one request for a single rising edge, then drop start.
    task automatic applyStimulus(input logic [31:0] op_a, input logic [31:0] op_b);
        @(negedge clk);
        start = 1'b1;
        a     = op_a;
        b     = op_b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count busy cycles until done is seen, with a cycle budget.
    task automatic waitDone(output int busy_cycles, output logic got_done);
        busy_cycles = 0;
        got_done    = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (busy) busy_cycles++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int          busy_cycles;
        logic        got_done;
        int          pulses;
        int          done_seen;
        logic [31:0] held;

        compared   = 0;
        mismatched = 0;

        vecs[0] = '{32'h0000_0001, 32'd4,          32'h0000_0010, 1'b0, 4};
        vecs[1] = '{32'h8000_0001, 32'd1,          32'h0000_0002, 1'b1, 1};
        vecs[2] = '{32'hDEAD_BEEF, 32'd0,          32'hDEAD_BEEF, 1'b0, 0};
        vecs[3] = '{32'hDEAD_BEEF, 32'd32,         32'h0000_0000, 1'b0, 0};
        vecs[4] = '{32'hDEAD_BEEF, 32'hFFFF_FFFF,  32'h0000_0000, 1'b0, 0};
        vecs[5] = '{32'hFFFF_FFFF, 32'd31,         32'h8000_0000, 1'b1, 31};
        vecs[6] = '{32'h1234_5678, 32'd4,          32'h2345_6780, 1'b1, 4};
        vecs[7] = '{32'h4000_0000, 32'd2,          32'h0000_0000, 1'b1, 2};
        vecs[8] = '{32'hA5A5_A5A5, 32'd16,         32'hA5A5_0000, 1'b1, 16};

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_result", result, 32'h0);
        checkOutput("reset_carry", {31'b0, carry_out}, 32'h0);
        checkOutput("reset_busy", {31'b0, busy}, 32'h0);
        checkOutput("reset_done", {31'b0, done}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven single operations.
        for (int v = 0; v < 9; v++) begin
            applyStimulus(vecs[v].a, vecs[v].b);
            waitDone(busy_cycles, got_done);
            checkOutput($sformatf("v%0d_done", v), {31'b0, got_done}, 32'h1);
            checkOutput($sformatf("v%0d_busy_cycles", v), busy_cycles, vecs[v].exp_busy);
            checkOutput($sformatf("v%0d_result", v), result, vecs[v].exp_result);
            checkOutput($sformatf("v%0d_carry", v), {31'b0, carry_out}, {31'b0, vecs[v].exp_carry});
            @(posedge clk);
            #1;
            checkOutput($sformatf("v%0d_done_pulse", v), {31'b0, done}, 32'h0);
            checkOutput($sformatf("v%0d_result_held", v), result, vecs[v].exp_result);
        end

        // Start pulsed mid-shift must not disturb the running operation.
        applyStimulus(32'hFFFF_FFFF, 32'd31);
        busy_cycles = 0;
        got_done    = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (busy) busy_cycles++;
            if (i == 5) begin
                start = 1'b1;
                a     = 32'h1;
                b     = 32'd2;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        checkOutput("ign_done", {31'b0, got_done}, 32'h1);
        checkOutput("ign_busy_cycles", busy_cycles, 31);
        checkOutput("ign_result", result, 32'h8000_0000);
        checkOutput("ign_carry", {31'b0, carry_out}, 32'h1);
        @(posedge clk);
        #1;
        checkOutput("ign_idle_busy", {31'b0, busy}, 32'h0);

        // Start held high through DONE launches a second operation.
        @(negedge clk);
        start = 1'b1;
        a     = 32'h8000_0001;
        b     = 32'd1;
        @(posedge clk);
        #1;
        a      = 32'h3;
        b      = 32'd2;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            if (done) begin
                pulses++;
                if (pulses == 1) begin
                    checkOutput("b2b_first_result", result, 32'h0000_0002);
                    checkOutput("b2b_first_carry", {31'b0, carry_out}, 32'h1);
                end else if (pulses == 2) begin
                    checkOutput("b2b_second_result", result, 32'h0000_000C);
                    checkOutput("b2b_second_carry", {31'b0, carry_out}, 32'h0);
                end
            end
            @(posedge clk);
            #1;
            if (pulses >= 1) start = 1'b0;
        end
        start = 1'b0;
        checkOutput("b2b_done_pulses", pulses, 2);

        // Reset in the middle of a long operation.
        applyStimulus(32'h00F0_000F, 32'd10);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        checkOutput("rst_pre_busy", {31'b0, busy}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_async_busy", {31'b0, busy}, 32'h0);
        checkOutput("rst_async_done", {31'b0, done}, 32'h0);
        checkOutput("rst_async_result", result, 32'h0);
        checkOutput("rst_async_carry", {31'b0, carry_out}, 32'h0);
        done_seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b1;
        a     = 32'h5;
        b     = 32'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("rst_first_edge_busy", {31'b0, busy}, 32'h1);
        waitDone(busy_cycles, got_done);
        checkOutput("rst_no_done_pulse", done_seen, 0);
        checkOutput("rst_next_done", {31'b0, got_done}, 32'h1);
        checkOutput("rst_next_busy_cycles", busy_cycles, 1);
        checkOutput("rst_next_result", result, 32'h0000_000A);
        checkOutput("rst_next_carry", {31'b0, carry_out}, 32'h0);
        held = result;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("idle_hold_result", result, 32'h0000_000A);
        checkOutput("idle_hold_done", {31'b0, done}, 32'h0);
        if (held !== 32'h0000_000A) begin
            mismatched++;
            compared++;
            $display("[TB] FAIL held_capture: got 0x%0h expected 0x%0h", held, 32'h0000_000A);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/seq_left_shifter.md
SEQ_LEFT_SHIFTER -- requirements
Module: seq_left_shifter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-002 The block SHALL expose exactly these ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- start  input  1  request; sampled only when accepted (see REQ-007)
- a  input  32  operand to shift
- b  input  32  shift amount, unsigned
- busy  output  1  high while shifting
- done  output  1  one-cycle completion pulse
- result  output  32  shifted value; valid when done=1, held until next accepted start
- carry_out  output  1  last bit shifted out of bit 31

Function
REQ-003 The block SHALL implement a logical left shift of a by b, zero-filling from bit 0, one bit position per clock.
REQ-004 The controller SHALL have three states: IDLE, SHIFT and DONE.
REQ-005 On an accepted start, the block SHALL load a into the working register, load b[4:0] into a 5-bit counter and clear carry_out.
REQ-006 On an accepted start, the next state SHALL be:
- DONE with result=0, carry_out=0, when b>31 (any of b[31:5] set)
- DONE with result=a, when b==0
- SHIFT otherwise
REQ-007 start SHALL be accepted in IDLE and in DONE, and SHALL be ignored in SHIFT (no effect on the operation in progress, no error).
REQ-008 On each clock edge in SHIFT, the block SHALL perform these updates:
- working register <= {work[30:0],1'b0}
- carry_out <= work[31]
- counter decrements
REQ-009 The controller SHALL go from SHIFT to DONE on the edge where the counter goes from 1 to 0.
REQ-010 From DONE, the next state SHALL be IDLE, or the new operation's state (per REQ-006) if start is high.
REQ-011 busy SHALL be high exactly when the state is SHIFT.
REQ-012 done SHALL be high exactly when the state is DONE, which lasts one cycle per operation.
REQ-013 Latency from the accepting edge to the first cycle with done=1 SHALL be 1 cycle for b==0 or b>31, and b cycles for 1<=b<=31.
REQ-014 carry_out at done SHALL be a[32-b] for 1<=b<=31, and 0 otherwise.
REQ-015 result and carry_out SHALL hold their values in IDLE until the next accepted start.
REQ-016 The block SHALL NOT use a combinational barrel shifter; the shift is iterative only.

Reset
REQ-017 While rst=1, the block SHALL hold these values, asynchronously and regardless of clk:
- state=IDLE
- result=0
- carry_out=0
- busy=0
- done=0
- counter=0
REQ-018 Asserting rst mid-operation SHALL abandon the operation with no done pulse.
REQ-019 After rst is deasserted, the first start SHALL be accepted on the first rising edge.

Structure
REQ-020 A shared package SHALL define the state encoding (IDLE/SHIFT/DONE), WORD_W=32 and SHAMT_W=5.
REQ-021 The block SHALL be a single module: one FSM, a 32-bit working register, a 5-bit counter and a carry flop, with no sub-module.

Verification
REQ-022 The bench SHALL cover at least these directed scenarios:
- a=0x00000001, b=4 -> busy high 4 cycles; done in cycle 4; result=0x00000010, carry_out=0.
- a=0x80000001, b=1 -> done after 1 cycle; result=0x00000002, carry_out=1.
- a=0xDEADBEEF, b=0 -> done after 1 cycle, busy never high; result=0xDEADBEEF. Same a with b=32 and b=0xFFFFFFFF -> result=0, carry_out=0, done after 1 cycle.
- a=0xFFFFFFFF, b=31 -> done after 31 cycles; result=0x80000000, carry_out=1. A start with a=0x1, b=2 pulsed during the SHIFT phase -> ignored, result unchanged.
- Back-to-back: start held high across DONE with a=0x3, b=2 -> second op accepted in DONE; done pulses twice; second result=0x0000000C.
- rst asserted at cycle 3 of a b=10 op -> outputs zero immediately; no done pulse; next start a=0x5, b=1 -> result=0xA.
